// File: rtl/seven_segment_bcd_counter.sv
// seven_segment_bcd_counter
//   Multi-digit BCD up/down counter with parallel load, a wrap pulse and a
//   time-multiplexed 7-segment driver. Anode and segment outputs are
//   registered.
//   Build option: define SEVEN_SEG_LEADING_ZERO_BLANK_EN to blank leading
//   zero digits. The least significant digit is always shown.
module seven_segment_bcd_counter #(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_HZ       = 50000000,
    parameter int TICK_HZ      = 1,
    parameter int REFRESH_BITS = 18,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clock_50Mhz,
    input  logic                    reset,
    input  logic                    count_enable,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] bcd_value,
    output logic                    wrap,
    output logic [NUM_DIGITS-1:0]   Anode_Activate,
    output logic [6:0]              LED_out
);

    localparam int PRESCALE = CLK_HZ / TICK_HZ;
    localparam int PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PS_W-1:0]       PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [6:0]            LED_OFF  = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

    logic [PS_W-1:0]         presc_q, presc_d;
    logic                    tick;
    logic [REFRESH_BITS-1:0] refresh_q;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
    logic                    wrap_q, wrap_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              led_q, led_d;
    logic [NUM_DIGITS-1:0]   lead_zero;

    // Active-low segment pattern (g..a); anything outside 0..9 is blank.
    function automatic logic [6:0] seg_lo(input logic [3:0] v);
        case (v)
            4'd0:    seg_lo = 7'b1000000;
            4'd1:    seg_lo = 7'b1111001;
            4'd2:    seg_lo = 7'b0100100;
            4'd3:    seg_lo = 7'b0110000;
            4'd4:    seg_lo = 7'b0011001;
            4'd5:    seg_lo = 7'b0010010;
            4'd6:    seg_lo = 7'b0000010;
            4'd7:    seg_lo = 7'b1111000;
            4'd8:    seg_lo = 7'b0000000;
            4'd9:    seg_lo = 7'b0010000;
            default: seg_lo = 7'b1111111;
        endcase
    endfunction

    // Free-running prescaler; tick marks its last count.
    always_comb begin
        tick    = (presc_q == PS_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Prescaler register.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) presc_q <= '0;
        else       presc_q <= presc_d;
    end

    // Counter next state: load beats tick, ripple carry/borrow through the digits.
    always_comb begin
        logic       carry;
        logic [3:0] nib;
        bcd_d  = bcd_q;
        wrap_d = 1'b0;
        carry  = 1'b0;
        nib    = 4'd0;
        if (load) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                nib = load_value[4*d +: 4];
                bcd_d[4*d +: 4] = (nib > 4'd9) ? 4'd0 : nib;
            end
        end else if (tick && count_enable) begin
            carry = 1'b1;
            for (int d = 0; d < NUM_DIGITS; d++) begin
                nib = bcd_q[4*d +: 4];
                if (carry) begin
                    if (!count_down) begin
                        if (nib == 4'd9) begin
                            bcd_d[4*d +: 4] = 4'd0;
                        end else begin
                            bcd_d[4*d +: 4] = nib + 4'd1;
                            carry = 1'b0;
                        end
                    end else begin
                        if (nib == 4'd0) begin
                            bcd_d[4*d +: 4] = 4'd9;
                        end else begin
                            bcd_d[4*d +: 4] = nib - 4'd1;
                            carry = 1'b0;
                        end
                    end
                end
            end
            // A carry out of the top digit means every digit rolled over.
            wrap_d = carry;
        end
    end

    // Counter and wrap registers.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            bcd_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            bcd_q  <= bcd_d;
            wrap_q <= wrap_d;
        end
    end

    // Digit index advances when the refresh counter rolls over.
    always_comb begin
        idx_d = idx_q;
        if (refresh_q == '1) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    // Refresh counter and digit index registers.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            refresh_q <= '0;
            idx_q     <= '0;
        end else begin
            refresh_q <= refresh_q + 1'b1;
            idx_q     <= idx_d;
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and all digits above it are zero.
    always_comb begin
        logic run;
        lead_zero = '0;
        run       = 1'b1;
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            run          = run & (bcd_q[4*d +: 4] == 4'd0);
            lead_zero[d] = run;
        end
    end
`else
    // Every digit is always shown.
    always_comb begin
        lead_zero = '0;
    end
`endif

    // Select the scanned digit (index 0 = most significant) and build the drive patterns.
    always_comb begin
        logic [NUM_DIGITS-1:0] an_hot;
        logic [3:0]            nib_sel;
        logic                  blank_sel;
        logic [6:0]            seg;
        an_hot    = '0;
        nib_sel   = 4'd0;
        blank_sel = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (d == NUM_DIGITS - 1 - int'(idx_q)) begin
                an_hot[d] = 1'b1;
                nib_sel   = bcd_q[4*d +: 4];
                blank_sel = lead_zero[d];
            end
        end
        seg   = blank_sel ? 7'b1111111 : seg_lo(nib_sel);
        led_d = (ACTIVE_LOW != 0) ? seg : ~seg;
        an_d  = (ACTIVE_LOW != 0) ? ~an_hot : an_hot;
    end

    // Registered display outputs.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            an_q  <= AN_OFF;
            led_q <= LED_OFF;
        end else begin
            an_q  <= an_d;
            led_q <= led_d;
        end
    end

    assign bcd_value      = bcd_q;
    assign wrap           = wrap_q;
    assign Anode_Activate = an_q;
    assign LED_out        = led_q;

endmodule
